vproc_bus_arbiter: RTL

- Shares one memory-mapped slave between NUM_MASTERS VProc bus masters.
- Masters use the VProc bus: Addr, WE, RD, DataOut, DataIn, WRAck, RDAck, Burst, BurstFirst, BurstLast.
- Grants are round-robin. A grant is held for a whole transaction: a single access, or all words of a burst. Other masters never see acks while they are not granted.
- Sits between the VProc instances and the test harness memory/peripheral model.

---
 rtl/vproc_bus_arbiter.sv | 135 +++++++++++++
 1 files changed

// File: rtl/vproc_bus_arbiter.sv
// Round-robin arbiter sharing one VProc bus slave between NUM_MASTERS masters.
// A grant is held until the word counter reports the final accepted word.
module vproc_bus_arbiter #(
    parameter int unsigned NUM_MASTERS = 2,
    parameter int unsigned IDX_WIDTH   = 3
) (
    input  logic                        Clk,
    input  logic                        nReset,
    input  logic [NUM_MASTERS*32-1:0]   MAddr,
    input  logic [NUM_MASTERS-1:0]      MWE,
    input  logic [NUM_MASTERS-1:0]      MRD,
    input  logic [NUM_MASTERS*32-1:0]   MDataOut,
    input  logic [NUM_MASTERS*12-1:0]   MBurst,
    input  logic [NUM_MASTERS-1:0]      MBurstFirst,
    input  logic [NUM_MASTERS-1:0]      MBurstLast,
    output logic [31:0]                 MDataIn,
    output logic [NUM_MASTERS-1:0]      MWRAck,
    output logic [NUM_MASTERS-1:0]      MRDAck,
    output logic [31:0]                 SAddr,
    output logic                        SWE,
    output logic                        SRD,
    output logic [31:0]                 SDataOut,
    output logic [11:0]                 SBurst,
    output logic                        SBurstFirst,
    output logic                        SBurstLast,
    input  logic [31:0]                 SDataIn,
    input  logic                        SWRAck,
    input  logic                        SRDAck,
    output logic [NUM_MASTERS-1:0]      Grant,
    output logic [IDX_WIDTH-1:0]        GrantIdx,
    output logic                        Busy
);

    localparam int unsigned AW = 32;
    localparam int unsigned BW = 12;

    typedef enum logic {IDLE, OWN} state_t;

    state_t                 state;
    logic [IDX_WIDTH-1:0]   last;
    logic [BW-1:0]          wcnt;

    logic [NUM_MASTERS-1:0]   req;
    logic [2*NUM_MASTERS-1:0] rot;
    logic                     pick_vld;
    logic [IDX_WIDTH-1:0]     pick;
    logic [BW-1:0]            pick_burst;
    logic                     accept;

    assign req     = MWE | MRD;
    assign MDataIn = SDataIn;
    assign accept  = (SWE & SWRAck) | (SRD & SRDAck);

    // Rotate requests so bit 0 is master last+1; the lowest set bit wins.
    always_comb begin
        pick_vld   = 1'b0;
        pick       = '0;
        pick_burst = '0;
        rot        = {req, req} >> (32'(last) + 32'd1);
        for (int j = NUM_MASTERS - 1; j >= 0; j--) begin
            if (rot[j]) begin
                pick_vld = 1'b1;
                pick     = IDX_WIDTH'((32'(last) + 32'(j) + 32'd1) % NUM_MASTERS);
            end
        end
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (pick == IDX_WIDTH'(i)) begin
                pick_burst = MBurst[BW*i +: BW];
            end
        end
    end

    // Forward the granted master to the slave and route acks back to it only.
    always_comb begin
        SAddr       = '0;
        SWE         = 1'b0;
        SRD         = 1'b0;
        SDataOut    = '0;
        SBurst      = '0;
        SBurstFirst = 1'b0;
        SBurstLast  = 1'b0;
        MWRAck      = '0;
        MRDAck      = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (Busy && GrantIdx == IDX_WIDTH'(i)) begin
                SAddr       = MAddr[AW*i +: AW];
                SWE         = MWE[i];
                SRD         = MRD[i];
                SDataOut    = MDataOut[AW*i +: AW];
                SBurst      = MBurst[BW*i +: BW];
                SBurstFirst = MBurstFirst[i];
                SBurstLast  = MBurstLast[i];
                MWRAck[i]   = SWRAck;
                MRDAck[i]   = SRDAck;
            end
        end
    end

    // Burst end comes from the counter: a single-word access never raises BurstLast.
    always_ff @(posedge Clk or negedge nReset) begin
        if (!nReset) begin
            state    <= IDLE;
            Grant    <= '0;
            GrantIdx <= '0;
            Busy     <= 1'b0;
            last     <= IDX_WIDTH'(NUM_MASTERS - 1);
            wcnt     <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_vld) begin
                        state    <= OWN;
                        Grant    <= NUM_MASTERS'(1) << pick;
                        GrantIdx <= pick;
                        last     <= pick;
                        Busy     <= 1'b1;
                        wcnt     <= (pick_burst == '0) ? BW'(1) : pick_burst;
                    end
                end
                OWN: begin
                    if (accept) begin
                        wcnt <= wcnt - BW'(1);
                        if (wcnt == BW'(1)) begin
                            state <= IDLE;
                            Grant <= '0;
                            Busy  <= 1'b0;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
